// File: rtl/spm_lsu.sv
// Load/store unit bridging core requests to a word-organised scratch-pad memory.
// Every output is registered; reqReady is a direct decode of the state register.
module spm_lsu #(
  parameter logic [31:0] spmBaseAddress = 32'hC0000000,
  parameter int          spmSizeInBytes = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        reqWe,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        reqReady,
  output logic        respValid,
  output logic        respError,
  output logic [31:0] respData,
  output logic        spmCs,
  output logic        spmWe,
  output logic [17:0] spmAddress,
  output logic [3:0]  spmByteEnables,
  output logic [31:0] dataToSpm,
  input  logic [31:0] dataFromSpm
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

  localparam logic [32:0] SPM_LIMIT = {1'b0, spmBaseAddress} + 33'(spmSizeInBytes);

  state_t      state, next_state;
  logic        accept, req_error, misaligned;
  logic        held_we, held_signed;
  logic [1:0]  held_size, held_lane;
  logic [31:0] shifted, aligned;

  logic        next_cs, next_we, next_resp_valid, next_resp_error;
  logic [17:0] next_addr;
  logic [3:0]  next_be;
  logic [31:0] next_wdata, next_resp_data;

  assign reqReady = (state == IDLE);
  assign accept   = reqReady && reqValid;

  always_comb begin
    misaligned = 1'b0;
    case (reqSize)
      2'b01:   misaligned = reqAddress[0];
      2'b10:   misaligned = (reqAddress[1:0] != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
    req_error = misaligned || (reqAddress < spmBaseAddress) ||
                ({1'b0, reqAddress} >= SPM_LIMIT);
  end

  // Load alignment: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted = dataFromSpm >> {held_lane, 3'b000};
    aligned = shifted;
    case (held_size)
      2'b00:   aligned = held_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'd0, shifted[7:0]};
      2'b01:   aligned = held_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'd0, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

  always_comb begin
    next_state      = state;
    next_cs         = 1'b0;
    next_we         = 1'b0;
    next_addr       = 18'd0;
    next_be         = 4'd0;
    next_wdata      = 32'd0;
    next_resp_valid = 1'b0;
    next_resp_error = 1'b0;
    next_resp_data  = 32'd0;
    case (state)
      IDLE: begin
        if (reqValid) begin
          if (req_error) begin
            next_state      = RESP;
            next_resp_valid = 1'b1;
            next_resp_error = 1'b1;
          end else begin
            next_state = ISSUE;
            next_cs    = 1'b1;
            next_we    = reqWe;
            next_addr  = 18'((reqAddress - spmBaseAddress) >> 2);
            case (reqSize)
              2'b00: begin
                next_be    = 4'b0001 << reqAddress[1:0];
                next_wdata = {4{reqWriteData[7:0]}};
              end
              2'b01: begin
                next_be    = reqAddress[1] ? 4'b1100 : 4'b0011;
                next_wdata = {2{reqWriteData[15:0]}};
              end
              default: begin
                next_be    = 4'b1111;
                next_wdata = reqWriteData;
              end
            endcase
          end
        end
      end
      ISSUE: begin
        if (held_we) begin
          next_state      = RESP;
          next_resp_valid = 1'b1;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: next_state = CAPTURE;
      CAPTURE: begin
        next_state      = RESP;
        next_resp_valid = 1'b1;
        next_resp_data  = aligned;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      spmCs          <= 1'b0;
      spmWe          <= 1'b0;
      spmAddress     <= 18'd0;
      spmByteEnables <= 4'd0;
      dataToSpm      <= 32'd0;
      respValid      <= 1'b0;
      respError      <= 1'b0;
      respData       <= 32'd0;
      held_we        <= 1'b0;
      held_signed    <= 1'b0;
      held_size      <= 2'd0;
      held_lane      <= 2'd0;
    end else begin
      state          <= next_state;
      spmCs          <= next_cs;
      spmWe          <= next_we;
      spmAddress     <= next_addr;
      spmByteEnables <= next_be;
      dataToSpm      <= next_wdata;
      respValid      <= next_resp_valid;
      respError      <= next_resp_error;
      respData       <= next_resp_data;
      if (accept) begin
        held_we     <= reqWe;
        held_signed <= reqSigned;
        held_size   <= reqSize;
        held_lane   <= reqAddress[1:0];
      end
    end
  end

endmodule

// File: tb/tb_spm_lsu.sv
// Directed bench for spm_lsu: stores, aligned/extended loads, error responses
// and reset abort, with expected values worked out by hand.
module tb_spm_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid, reqWe, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddress, reqWriteData;
  logic        reqReady, respValid, respError;
  logic [31:0] respData;
  logic        spmCs, spmWe;
  logic [17:0] spmAddress;
  logic [3:0]  spmByteEnables;
  logic [31:0] dataToSpm, dataFromSpm;

  int vectors = 0;
  int miscompares = 0;

  spm_lsu dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqWe(reqWe), .reqSize(reqSize), .reqSigned(reqSigned),
    .reqAddress(reqAddress), .reqWriteData(reqWriteData), .reqReady(reqReady),
    .respValid(respValid), .respError(respError), .respData(respData),
    .spmCs(spmCs), .spmWe(spmWe), .spmAddress(spmAddress),
    .spmByteEnables(spmByteEnables), .dataToSpm(dataToSpm), .dataFromSpm(dataFromSpm)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single edge (the accept edge) and returns in cycle T+1.
  task automatic request(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
    reqValid = 1'b1; reqWe = we; reqSize = size; reqSigned = sgn;
    reqAddress = addr; reqWriteData = wdata;
    tick();
    reqValid = 1'b0;
  endtask

  task automatic error_case(input string tag, input logic [1:0] size, input logic [31:0] addr);
    check({tag, " ready"}, 32'(reqReady), 32'd1);
    request(1'b0, size, 1'b0, addr, 32'h0);
    check({tag, " cs"}, 32'(spmCs), 32'd0);
    check({tag, " valid"}, 32'(respValid), 32'd1);
    check({tag, " error"}, 32'(respError), 32'd1);
    check({tag, " data"}, respData, 32'd0);
    tick();
    check({tag, " cs after"}, 32'(spmCs), 32'd0);
    check({tag, " valid drop"}, 32'(respValid), 32'd0);
  endtask

  task automatic load_case(input string tag, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] mem,
                           input logic [17:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
    dataFromSpm = mem;
    request(1'b0, size, sgn, addr, 32'h0);
    check({tag, " cs"}, 32'(spmCs), 32'd1);
    check({tag, " we"}, 32'(spmWe), 32'd0);
    check({tag, " addr"}, 32'(spmAddress), 32'(exp_addr));
    check({tag, " be"}, 32'(spmByteEnables), 32'(exp_be));
    tick();
    check({tag, " cs wait"}, 32'(spmCs), 32'd0);
    tick();
    check({tag, " valid early"}, 32'(respValid), 32'd0);
    tick();
    check({tag, " valid"}, 32'(respValid), 32'd1);
    check({tag, " error"}, 32'(respError), 32'd0);
    check({tag, " data"}, respData, exp_data);
    tick();
    check({tag, " valid drop"}, 32'(respValid), 32'd0);
  endtask

  initial begin
    reset = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddress = 32'h0; reqWriteData = 32'h0; dataFromSpm = 32'h0;
    tick(); tick();
    check("reset valid", 32'(respValid), 32'd0);
    check("reset cs", 32'(spmCs), 32'd0);
    check("reset data", respData, 32'd0);
    reset = 1'b1;
    tick();
    check("ready after reset", 32'(reqReady), 32'd1);

    // Word store, checked cycle by cycle.
    request(1'b1, 2'b10, 1'b0, 32'hC0000010, 32'hDEADBEEF);
    check("st cs", 32'(spmCs), 32'd1);
    check("st we", 32'(spmWe), 32'd1);
    check("st addr", 32'(spmAddress), 32'd4);
    check("st be", 32'(spmByteEnables), 32'hF);
    check("st wdata", dataToSpm, 32'hDEADBEEF);
    check("st ready busy", 32'(reqReady), 32'd0);
    tick();
    check("st valid", 32'(respValid), 32'd1);
    check("st error", 32'(respError), 32'd0);
    check("st cs off", 32'(spmCs), 32'd0);
    check("st wdata off", dataToSpm, 32'd0);
    tick();
    check("st ready again", 32'(reqReady), 32'd1);

    // Narrow stores replicate the data across lanes.
    request(1'b1, 2'b00, 1'b0, 32'hC0000001, 32'h000000A5);
    check("stb be", 32'(spmByteEnables), 32'b0010);
    check("stb wdata", dataToSpm, 32'hA5A5A5A5);
    tick(); tick();
    request(1'b1, 2'b01, 1'b0, 32'hC0000002, 32'h1234ABCD);
    check("sth be", 32'(spmByteEnables), 32'b1100);
    check("sth wdata", dataToSpm, 32'hABCDABCD);
    tick(); tick();

    load_case("lb signed",   2'b00, 1'b1, 32'hC0000013, 32'h80FF1234, 18'd4, 4'b1000, 32'hFFFFFF80);
    load_case("lbu",         2'b00, 1'b0, 32'hC0000013, 32'h80FF1234, 18'd4, 4'b1000, 32'h00000080);
    load_case("lhu",         2'b01, 1'b0, 32'hC0000006, 32'h9ABC5678, 18'd1, 4'b1100, 32'h00009ABC);
    load_case("lh signed",   2'b01, 1'b1, 32'hC0000006, 32'h9ABC5678, 18'd1, 4'b1100, 32'hFFFF9ABC);
    load_case("lh low",      2'b01, 1'b1, 32'hC0000004, 32'h9ABC5678, 18'd1, 4'b0011, 32'h00005678);
    load_case("lw top",      2'b10, 1'b1, 32'hC00007FC, 32'h81223344, 18'h1FF, 4'b1111, 32'h81223344);

    error_case("misaligned word", 2'b10, 32'hC0000002);
    error_case("odd half",        2'b01, 32'hC0000005);
    error_case("past end",        2'b10, 32'hC0000800);
    error_case("below base",      2'b10, 32'hBFFFFFFC);
    error_case("illegal size",    2'b11, 32'hC0000000);

    // Requests held while busy must not start a second access.
    dataFromSpm = 32'h0000_00C3;
    reqValid = 1'b1; reqWe = 1'b0; reqSize = 2'b00; reqSigned = 1'b0; reqAddress = 32'hC0000008;
    tick();
    check("busy issue cs", 32'(spmCs), 32'd1);
    tick();
    check("busy wait cs", 32'(spmCs), 32'd0);
    tick();
    check("busy capture cs", 32'(spmCs), 32'd0);
    reqValid = 1'b0;
    tick();
    check("busy resp data", respData, 32'h000000C3);
    tick();

    // Reset during WAIT abandons the load.
    dataFromSpm = 32'h12345678;
    request(1'b0, 2'b10, 1'b0, 32'hC0000020, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("abort valid", 32'(respValid), 32'd0);
    check("abort cs", 32'(spmCs), 32'd0);
    reset = 1'b1;
    check("abort ready", 32'(reqReady), 32'd1);
    tick();
    check("abort no late resp", 32'(respValid), 32'd0);
    tick();
    check("abort no late cs", 32'(spmCs), 32'd0);
    request(1'b1, 2'b10, 1'b0, 32'hC0000020, 32'h55AA55AA);
    check("post store cs", 32'(spmCs), 32'd1);
    check("post store addr", 32'(spmAddress), 32'd8);
    check("post store wdata", dataToSpm, 32'h55AA55AA);
    tick();
    check("post store valid", 32'(respValid), 32'd1);
    check("post store error", 32'(respError), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spm_lsu.md
SPM_LSU -- requirements
Module: spm_lsu

Interface
REQ-001 SHALL have parameter spmBaseAddress, default 32'hC0000000, byte address of scratch-pad byte 0.
REQ-002 SHALL have parameter spmSizeInBytes, default 2048, scratch-pad size; power of two, multiple of 4.
REQ-003 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports reqValid in 1, reqWe in 1, reqSize in 2 (00 byte, 01 half, 10 word, 11 illegal), reqSigned in 1, reqAddress in 32, reqWriteData in 32: core load/store request.
REQ-006 SHALL have port reqReady  out  1  request accepted this cycle when reqValid is also 1.
REQ-007 SHALL have ports respValid out 1, respError out 1, respData out 32: one-cycle response.
REQ-008 SHALL have SPM-side ports spmCs out 1, spmWe out 1, spmAddress out 18 (word address), spmByteEnables out 4, dataToSpm out 32, dataFromSpm in 32.

Function
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, CAPTURE, RESP; reqReady SHALL be 1 only in IDLE.
REQ-010 SHALL, on accept (IDLE, reqValid=1), register all request fields and compute error = reqSize==11, or half with addr[0]=1, or word with addr[1:0]!=0, or addr < base, or addr >= base+spmSizeInBytes.
REQ-011 SHALL, on accept with error, go IDLE->RESP; SPM outputs stay idle; respError=1 and respData=0 in RESP.
REQ-012 SHALL, on accept without error, go IDLE->ISSUE; spmCs=1 for exactly that one ISSUE cycle; spmWe=reqWe.
REQ-013 SHALL drive spmAddress = ((addr - base) >> 2), zero-extended to 18 bits, during ISSUE.
REQ-014 SHALL drive spmByteEnables in ISSUE as follows, for both loads and stores: byte = 1 << addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
REQ-015 SHALL drive dataToSpm in ISSUE as follows: byte = wdata[7:0] replicated x4; half = wdata[15:0] replicated x2; word = wdata unchanged.
REQ-016 SHALL, for a store, go ISSUE->RESP, with respData=0 and respError=0 in RESP.
REQ-017 SHALL, for a load, go ISSUE->WAIT->CAPTURE->RESP, and sample dataFromSpm at the end of CAPTURE (SPM read latency of 2 cycles after chip select).
REQ-018 SHALL align load data by shifting right by 8*addr[1:0]; byte and half results SHALL be sign-extended if reqSigned=1, else zero-extended; reqSigned is ignored for word.
REQ-019 SHALL assert respValid for exactly one cycle (RESP), then go RESP->IDLE.
REQ-020 SHALL register all outputs; spmCs, spmWe, spmByteEnables and dataToSpm SHALL be 0 outside ISSUE.
REQ-021 SHALL have latency (accept edge = T): error response at T+1; store chip select at T+1, response at T+2; load chip select at T+1, response at T+4.
REQ-022 SHALL ignore reqValid outside IDLE; no request queuing.
REQ-023 SHALL have peak throughput of one store per 3 cycles and one load per 5 cycles.

Reset
REQ-024 SHALL, while reset=0 at a rising edge, enter IDLE and clear all registered outputs to 0; reqReady SHALL be 1 in the first cycle after reset is released.
REQ-025 SHALL, on reset during any non-IDLE state, abandon the transaction: no respValid and no further spmCs.

Verification
REQ-026 Word store of 0xDEADBEEF to 0xC0000010 -> T+1: spmCs=1, spmWe=1, spmAddress=4, spmByteEnables=1111, dataToSpm=0xDEADBEEF; T+2: respValid=1, respError=0.
REQ-027 Signed byte load from 0xC0000013 with dataFromSpm=0x80FF1234 -> T+1: spmByteEnables=1000; T+4: respData=0xFFFFFF80.
REQ-028 Unsigned half load from 0xC0000006 with dataFromSpm=0x9ABC5678 -> T+4: respData=0x00009ABC; same access with reqSigned=1 -> respData=0xFFFF9ABC.
REQ-029 Each of the following -> spmCs never 1, T+1: respValid=1, respError=1: word at 0xC0000002, access at 0xC0000800, access at 0xBFFFFFFC, reqSize=11.
REQ-030 Word load at 0xC00007FC -> spmAddress=0x1FF, respError=0.
REQ-031 Load accepted, reset=0 in WAIT -> no respValid, spmCs=0; after release reqReady=1, and the next store completes normally.
